// File: rtl/adder_nbit_pipe.sv
// rtl/adder_nbit_pipe.sv - WIDTH-bit adder split into STAGES carry-linked slices, valid/ready at both ends
// Optional feature macro: ADDER_NBIT_SAT_EN (saturate sum on signed overflow in the last stage)
module adder_nbit_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ov_q;

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] pv;
    logic [STAGES-1:0] pc;
    logic [WIDTH-1:0]  pa [STAGES];
    logic [WIDTH-1:0]  pb [STAGES];
    logic [WIDTH-1:0]  ps [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_d;
    logic [SW:0]       slice;
    logic              msb_cin;
    logic              ov_d;

    // A stage may load when it is empty or its occupant moves on this cycle.
    always_comb begin
        ld       = '0;
        ld[LAST] = !v_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end
    end

    always_comb begin
        pv    = '0;
        pc    = '0;
        pa    = '{default: '0};
        pb    = '{default: '0};
        ps    = '{default: '0};
        pv[0] = in_valid;
        pc[0] = carry_in;
        pa[0] = a;
        pb[0] = b;
        for (int k = 1; k < STAGES; k++) begin
            pv[k] = v_q[k-1];
            pc[k] = c_q[k-1];
            pa[k] = a_q[k-1];
            pb[k] = b_q[k-1];
            ps[k] = s_q[k-1];
        end
    end

    // Each stage fills in its own slice of the sum and forwards the slice carry.
    always_comb begin
        slice   = '0;
        c_d     = '0;
        s_d     = '{default: '0};
        msb_cin = 1'b0;
        ov_d    = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, pa[k][k*SW +: SW]} + {1'b0, pb[k][k*SW +: SW]} + {{SW{1'b0}}, pc[k]};
            s_d[k] = ps[k];
            s_d[k][k*SW +: SW] = slice[SW-1:0];
            c_d[k] = slice[SW];
        end
        msb_cin = pa[LAST][WIDTH-1] ^ pb[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1];
        ov_d    = msb_cin ^ c_d[LAST];
`ifdef ADDER_NBIT_SAT_EN
        if (ov_d) begin
            s_d[LAST] = pa[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Data only loads alongside a valid entry so held outputs never pick up bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            c_q  <= '0;
            ov_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= pv[k];
                    if (pv[k]) begin
                        a_q[k] <= pa[k];
                        b_q[k] <= pb[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (ld[LAST] && pv[LAST]) begin
                ov_q <= ov_d;
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign carry_out = c_q[LAST];
    assign overflow  = ov_q;

    always @(posedge clk) begin
        assert (WIDTH % STAGES == 0)
            else $error("adder_nbit_pipe: WIDTH must be a multiple of STAGES");
        if (!rst && in_valid) begin
            assert (!$isunknown({a, b, carry_in}))
                else $error("adder_nbit_pipe: X/Z on operands while in_valid");
        end
    end
endmodule
